// File: rtl/decompose_w1_decode.sv
// decompose_w1_decode: unpacks 64-bit w1 words into one group of four 4-bit r1 coefficients per cycle.
//
// Ports:
//   clk          in   clock
//   reset_n      in   asynchronous active-low reset
//   zeroize      in   synchronous clear of all state (wins over everything but reset)
//   start_i      in   pulse: clear buffers/counters and enter RUN
//   w1_i         in   64-bit packed word, bits [15:0] are the first group
//   w1_valid_i   in   w1_i valid
//   w1_ready_o   out  word can be accepted this cycle
//   r1_o         out  current group, r1_o[0] is the lowest nibble
//   r1_valid_o   out  r1_o valid
//   r1_ready_i   in   consumer accepts r1_o
//   poly_done_o  out  pulse with the handshake of a polynomial's last group
//   done_o       out  sticky: NUM_POLY polynomials emitted
//   proto_err_o  out  sticky input-protocol violation
//
// Build option: define W1_DECODE_PROTO_CHK_EN to enable the input protocol checker;
// otherwise proto_err_o is tied low.
module decompose_w1_decode #(
    parameter int NUM_POLY        = 8,
    parameter int GROUPS_PER_POLY = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            zeroize,
    input  logic            start_i,
    input  logic [63:0]     w1_i,
    input  logic            w1_valid_i,
    output logic            w1_ready_o,
    output logic [3:0][3:0] r1_o,
    output logic            r1_valid_o,
    input  logic            r1_ready_i,
    output logic            poly_done_o,
    output logic            done_o,
    output logic            proto_err_o
);
    localparam int GW = GROUPS_PER_POLY > 1 ? $clog2(GROUPS_PER_POLY) : 1;
    localparam int PW = NUM_POLY > 1 ? $clog2(NUM_POLY) : 1;
    localparam logic [GW-1:0] GRP_LAST  = GW'(GROUPS_PER_POLY - 1);
    localparam logic [PW-1:0] POLY_LAST = PW'(NUM_POLY - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [63:0]   sr_q, sr_d, hold_q, hold_d;
    logic          sr_full_q, sr_full_d, hold_full_q, hold_full_d;
    logic [1:0]    sub_q, sub_d;
    logic [GW-1:0] grp_cnt_q, grp_cnt_d;
    logic [PW-1:0] poly_cnt_q, poly_cnt_d;
    logic          done_q, done_d;
    logic          run, accept, out_hs, sr_avail, op_done;

    always_comb begin
        run         = state_q == RUN;
        w1_ready_o  = run & ~hold_full_q;
        accept      = w1_valid_i & w1_ready_o;
        r1_valid_o  = run & sr_full_q;
        r1_o        = sr_q[15:0];
        out_hs      = r1_valid_o & r1_ready_i;
        poly_done_o = out_hs & (grp_cnt_q == GRP_LAST);
        op_done     = poly_done_o & (poly_cnt_q == POLY_LAST);
        done_o      = done_q;
        // SR can take new data when empty or when its last group leaves this cycle
        sr_avail    = ~sr_full_q | (out_hs & (sub_q == 2'd3));
        state_d     = state_q;
        sr_d        = sr_q;
        hold_d      = hold_q;
        sr_full_d   = sr_full_q;
        hold_full_d = hold_full_q;
        sub_d       = sub_q;
        grp_cnt_d   = grp_cnt_q;
        poly_cnt_d  = poly_cnt_q;
        done_d      = done_q;
        if (state_q == IDLE && start_i)
            state_d = RUN;
        if (out_hs) begin
            sr_d       = sr_q >> 16;
            sub_d      = sub_q + 2'd1;
            sr_full_d  = sub_q != 2'd3;
            grp_cnt_d  = poly_done_o ? '0 : grp_cnt_q + 1'b1;
            poly_cnt_d = poly_done_o ? poly_cnt_q + 1'b1 : poly_cnt_q;
        end
        // HOLD refills SR before a new word so ordering is preserved
        if (sr_avail & hold_full_q) begin
            sr_d        = hold_q;
            sr_full_d   = 1'b1;
            sub_d       = 2'd0;
            hold_full_d = 1'b0;
        end else if (sr_avail & accept) begin
            sr_d      = w1_i;
            sr_full_d = 1'b1;
            sub_d     = 2'd0;
        end else if (accept) begin
            hold_d      = w1_i;
            hold_full_d = 1'b1;
        end
        if (op_done) begin
            state_d     = DONE;
            done_d      = 1'b1;
            sr_full_d   = 1'b0;
            hold_full_d = 1'b0;
            poly_cnt_d  = '0;
        end
        if (start_i | zeroize) begin
            state_d     = zeroize ? IDLE : RUN;
            sr_d        = '0;
            hold_d      = '0;
            sr_full_d   = 1'b0;
            hold_full_d = 1'b0;
            sub_d       = '0;
            grp_cnt_d   = '0;
            poly_cnt_d  = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            hold_q      <= '0;
            sr_full_q   <= 1'b0;
            hold_full_q <= 1'b0;
            sub_q       <= '0;
            grp_cnt_q   <= '0;
            poly_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            hold_q      <= hold_d;
            sr_full_q   <= sr_full_d;
            hold_full_q <= hold_full_d;
            sub_q       <= sub_d;
            grp_cnt_q   <= grp_cnt_d;
            poly_cnt_q  <= poly_cnt_d;
            done_q      <= done_d;
        end
    end

`ifdef W1_DECODE_PROTO_CHK_EN
    logic        proto_err_q, proto_err_d, stall_q, stall_d;
    logic [63:0] w1_prev_q, w1_prev_d;

    // A stalled offer must stay valid with unchanged data; any offer outside RUN is illegal
    always_comb begin
        stall_d     = w1_valid_i & ~w1_ready_o;
        w1_prev_d   = w1_i;
        proto_err_d = proto_err_q | (stall_q & (~w1_valid_i | (w1_i != w1_prev_q))) | (w1_valid_i & ~run);
        if (start_i | zeroize) begin
            stall_d     = 1'b0;
            proto_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            proto_err_q <= 1'b0;
            stall_q     <= 1'b0;
            w1_prev_q   <= '0;
        end else begin
            proto_err_q <= proto_err_d;
            stall_q     <= stall_d;
            w1_prev_q   <= w1_prev_d;
        end
    end

    assign proto_err_o = proto_err_q;
`else
    assign proto_err_o = 1'b0;
`endif
endmodule
